// File: rtl/systolic_pkg.sv
// Shared types and phase-length helpers for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

    // One extra cycle so the last fetched row can be accepted a cycle after its read.
    function automatic int load_len(input int n);
        return n + 1;
    endfunction

    // East skew plus south psum travel.
    function automatic int drain_len(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/row_skew.sv
// Row-skew shift register: row r sees the row-0 switch/valid strobes r cycles later.
module row_skew #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         sw_in,
    input  logic         valid_in,
    output logic [N-1:0] sw_row,
    output logic [N-1:0] valid_row
);

    logic [N:0] sw_src;
    logic [N:0] valid_src;

    assign sw_src    = {sw_row, sw_in};
    assign valid_src = {valid_row, valid_in};

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            sw_row    <= '0;
            valid_row <= '0;
        end else begin
            sw_row    <= sw_src[N-1:0];
            valid_row <= valid_src[N-1:0];
        end
    end

endmodule

// File: rtl/systolic_seq.sv
// Job sequencer for an NxN systolic array: weight load, skewed switch, input stream, drain.
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int N       = 4,
    parameter int MAX_VEC = 256,
    parameter int CNT_W   = $clog2(MAX_VEC + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_vec,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic                 array_en,
    output logic                 wbuf_rd_en,
    output logic [$clog2(N)-1:0] wbuf_rd_addr,
    output logic [N-1:0]         accept_w,
    output logic                 ibuf_rd_en,
    output logic [CNT_W-1:0]     ibuf_rd_addr,
    output logic [N-1:0]         sw_row,
    output logic [N-1:0]         valid_row
);

    localparam int AW = $clog2(N);
    localparam int TW = CNT_W + 1;  // STREAM runs to K+N-1, which exceeds CNT_W bits at K=MAX_VEC

    localparam logic [TW-1:0]    ONE_T      = TW'(1);
    localparam logic [TW-1:0]    N_T        = TW'(N);
    localparam logic [TW-1:0]    LOAD_LAST  = TW'(load_len(N) - 1);
    localparam logic [TW-1:0]    DRAIN_LAST = TW'(drain_len(N) - 1);
    localparam logic [CNT_W-1:0] MAX_K      = CNT_W'(MAX_VEC);
    localparam logic [AW-1:0]    TOP_ROW    = AW'(N - 1);

    seq_state_t       state_reg, state_next;
    logic [TW-1:0]    cnt_reg, cnt_next;
    logic [CNT_W-1:0] k_reg, k_next;
    logic             array_en_reg, array_en_next;
    logic             done_reg, done_next;
    logic             cfg_err_reg, cfg_err_next;
    logic             busy_reg, busy_next;
    logic             wbuf_rd_en_reg, wbuf_rd_en_next;
    logic [AW-1:0]    wbuf_rd_addr_reg, wbuf_rd_addr_next;
    logic [N-1:0]     accept_w_reg, accept_w_next;
    logic             ibuf_rd_en_reg, ibuf_rd_en_next;
    logic [CNT_W-1:0] ibuf_rd_addr_reg, ibuf_rd_addr_next;
    logic             sw0_next, valid0_next;
    logic             abort_hit;
    logic [TW-1:0]    stream_last;
    logic [TW-1:0]    k_ext_next;

    assign abort_hit   = abort && (state_reg != IDLE);
    assign stream_last = {1'b0, k_reg} + N_T - ONE_T;
    assign k_ext_next  = {1'b0, k_next};

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg + ONE_T;
        k_next        = k_reg;
        array_en_next = array_en_reg;
        done_next     = 1'b0;
        cfg_err_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start) begin
                    if (num_vec != '0 && num_vec <= MAX_K) begin
                        state_next    = LOAD_W;
                        k_next        = num_vec;
                        array_en_next = 1'b1;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            LOAD_W: if (cnt_reg == LOAD_LAST) begin
                state_next = STREAM;
                cnt_next   = '0;
            end
            STREAM: if (cnt_reg == stream_last) begin
                state_next = DRAIN;
                cnt_next   = '0;
            end
            DRAIN: if (cnt_reg == DRAIN_LAST) begin
                state_next = IDLE;
                cnt_next   = '0;
                done_next  = 1'b1;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        // Abort wins over every transition, but only once a job is running.
        if (abort_hit) begin
            state_next    = IDLE;
            cnt_next      = '0;
            array_en_next = 1'b0;
            done_next     = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they appear registered in the cycle they describe.
    always_comb begin
        busy_next         = (state_next != IDLE);
        wbuf_rd_en_next   = (state_next == LOAD_W) && (cnt_next < N_T);
        wbuf_rd_addr_next = wbuf_rd_en_next ? (TOP_ROW - cnt_next[AW-1:0]) : '0;
        accept_w_next     = ((state_next == LOAD_W) && (cnt_next >= ONE_T)) ? '1 : '0;
        ibuf_rd_en_next   = (state_next == STREAM) && (cnt_next < k_ext_next);
        ibuf_rd_addr_next = ibuf_rd_en_next ? cnt_next[CNT_W-1:0] : '0;
        sw0_next          = (state_next == STREAM) && (cnt_next == '0);
        valid0_next       = (state_next == STREAM) && (cnt_next >= ONE_T)
                            && (cnt_next <= k_ext_next);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            k_reg            <= '0;
            array_en_reg     <= 1'b0;
            done_reg         <= 1'b0;
            cfg_err_reg      <= 1'b0;
            busy_reg         <= 1'b0;
            wbuf_rd_en_reg   <= 1'b0;
            wbuf_rd_addr_reg <= '0;
            accept_w_reg     <= '0;
            ibuf_rd_en_reg   <= 1'b0;
            ibuf_rd_addr_reg <= '0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            k_reg            <= k_next;
            array_en_reg     <= array_en_next;
            done_reg         <= done_next;
            cfg_err_reg      <= cfg_err_next;
            busy_reg         <= busy_next;
            wbuf_rd_en_reg   <= wbuf_rd_en_next;
            wbuf_rd_addr_reg <= wbuf_rd_addr_next;
            accept_w_reg     <= accept_w_next;
            ibuf_rd_en_reg   <= ibuf_rd_en_next;
            ibuf_rd_addr_reg <= ibuf_rd_addr_next;
        end
    end

    row_skew #(.N(N)) u_row_skew (
        .clk       (clk),
        .rst       (rst),
        .clear     (abort_hit),
        .sw_in     (sw0_next),
        .valid_in  (valid0_next),
        .sw_row    (sw_row),
        .valid_row (valid_row)
    );

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign cfg_err      = cfg_err_reg;
    assign array_en     = array_en_reg;
    assign wbuf_rd_en   = wbuf_rd_en_reg;
    assign wbuf_rd_addr = wbuf_rd_addr_reg;
    assign accept_w     = accept_w_reg;
    assign ibuf_rd_en   = ibuf_rd_en_reg;
    assign ibuf_rd_addr = ibuf_rd_addr_reg;

endmodule
